dcache_dm_refill: RTL

//  Parametrised direct-mapped, write-through, no-write-allocate L1 data cache between the LSU and data memory.

---
 rtl/dcache_dm_refill_if.sv | 47 ++++
 rtl/dcache_dm_refill.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_dm_refill_if.sv
// LSU-side and memory-side signal bundles for the direct-mapped refill data cache.

interface dcache_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [5:0]  req_rd;
   logic [31:0] req_pc;
   logic        resp_valid;
   logic [3:0]  resp_op;
   logic [5:0]  resp_rd;
   logic [31:0] resp_pc;
   logic [31:0] resp_addr;
   logic [31:0] resp_data;
   logic        resp_hit;

   modport master (
      output req_valid, req_op, req_addr, req_wdata, req_rd, req_pc,
      input  req_ready, resp_valid, resp_op, resp_rd, resp_pc, resp_addr, resp_data, resp_hit
   );
   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, req_rd, req_pc,
      output req_ready, resp_valid, resp_op, resp_rd, resp_pc, resp_addr, resp_data, resp_hit
   );
endinterface

interface dcache_mem_if;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_we;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;

   modport master (
      output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data
   );
   modport slave (
      input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data
   );
endinterface

// File: rtl/dcache_dm_refill.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with blocking line refill.
// Define DCACHE_STATS_EN to add the hit_cnt/miss_cnt statistics ports.

module dcache_dm_refill #(
   parameter int NUM_LINES  = 256,
   parameter int LINE_WORDS = 4
) (
   input  logic         clk,
   input  logic         rstn,
   dcache_lsu_if.slave  lsu,
   dcache_mem_if.master mem
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]  hit_cnt,
   output logic [31:0]  miss_cnt
`endif
);

   localparam int INDEX_W = $clog2(NUM_LINES);
   localparam int LW_BITS = $clog2(LINE_WORDS);
   localparam int OFF_W   = LW_BITS + 2;
   localparam int TAG_W   = 32 - INDEX_W - OFF_W;
   localparam int CNT_W   = (LW_BITS > 0) ? LW_BITS : 1;

   localparam logic [3:0] OP_LB = 4'd7;
   localparam logic [3:0] OP_LW = 4'd8;
   localparam logic [3:0] OP_SB = 4'd9;
   localparam logic [3:0] OP_SW = 4'd10;

   typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESP} state_t;

   state_t state_q, state_d;

   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]     tagArr_q  [NUM_LINES];
   logic [31:0]          dataArr_q [NUM_LINES][LINE_WORDS];

   logic [3:0]       reqOp_q;
   logic [31:0]      reqAddr_q, reqWdata_q, reqPc_q;
   logic [5:0]       reqRd_q;
   logic [CNT_W-1:0] refillCnt_q;
   logic             rdPending_q;
   logic             respValid_q, respHit_q;
   logic [31:0]      respData_q;

   function automatic logic [INDEX_W-1:0] idxOf(input logic [31:0] a);
      return INDEX_W'(a >> OFF_W);
   endfunction

   function automatic logic [TAG_W-1:0] tagOf(input logic [31:0] a);
      return TAG_W'(a >> (OFF_W + INDEX_W));
   endfunction

   function automatic logic [CNT_W-1:0] wordOf(input logic [31:0] a);
      return CNT_W'((a >> 2) & 32'(LINE_WORDS - 1));
   endfunction

   function automatic logic [31:0] loadFmt(input logic [3:0] op, input logic [31:0] w,
                                          input logic [1:0] b);
      logic [31:0] sh;
      sh = w >> {b, 3'b000};
      return (op == OP_LB) ? {24'b0, sh[7:0]} : w;
   endfunction

   logic             accept, isLoad, isStore, lookupHit, reqHit;
   logic [INDEX_W-1:0] lookupIdx, reqIdx;
   logic [CNT_W-1:0] reqWord;
   logic [31:0]      lookupWord, laneData, refillAddr;
   logic [3:0]       laneStrb;
   logic             memReqValid, refillIssue, rspFire, lastWord, writeFire;

   assign accept     = lsu.req_valid && (state_q == IDLE);
   assign isLoad     = (lsu.req_op == OP_LB) || (lsu.req_op == OP_LW);
   assign isStore    = (lsu.req_op == OP_SB) || (lsu.req_op == OP_SW);
   assign lookupIdx  = idxOf(lsu.req_addr);
   assign lookupHit  = valid_q[lookupIdx] && (tagArr_q[lookupIdx] == tagOf(lsu.req_addr));
   assign lookupWord = dataArr_q[lookupIdx][wordOf(lsu.req_addr)];

   assign reqIdx     = idxOf(reqAddr_q);
   assign reqWord    = wordOf(reqAddr_q);
   assign reqHit     = valid_q[reqIdx] && (tagArr_q[reqIdx] == tagOf(reqAddr_q));
   assign refillAddr = (reqAddr_q & ~32'(LINE_WORDS * 4 - 1)) | (32'(refillCnt_q) << 2);

   // SB places its byte in the lane selected by the low address bits
   assign laneStrb = (reqOp_q == OP_SW) ? 4'hF : (4'b0001 << reqAddr_q[1:0]);
   assign laneData = (reqOp_q == OP_SW) ? reqWdata_q
                                        : ({24'b0, reqWdata_q[7:0]} << {reqAddr_q[1:0], 3'b000});

   assign refillIssue = (state_q == REFILL) && memReqValid && mem.mem_req_ready;
   assign rspFire     = (state_q == REFILL) && rdPending_q && mem.mem_rsp_valid;
   assign lastWord    = (refillCnt_q == CNT_W'(LINE_WORDS - 1));
   assign writeFire   = (state_q == WRITE) && mem.mem_req_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && isLoad && !lookupHit) state_d = REFILL;
                  else if (accept && isStore)         state_d = WRITE;
         REFILL:  if (rspFire && lastWord)            state_d = RESP;
         WRITE:   if (writeFire)                      state_d = RESP;
         default:                                     state_d = IDLE;
      endcase
   end

   always_comb begin
      lsu.req_ready     = (state_q == IDLE);
      memReqValid       = 1'b0;
      mem.mem_req_we    = 1'b0;
      mem.mem_req_addr  = '0;
      mem.mem_req_wdata = '0;
      mem.mem_req_wstrb = '0;
      case (state_q)
         REFILL: begin
            memReqValid      = !rdPending_q;
            mem.mem_req_addr = refillAddr;
         end
         WRITE: begin
            memReqValid       = 1'b1;
            mem.mem_req_we    = 1'b1;
            mem.mem_req_addr  = {reqAddr_q[31:2], 2'b00};
            mem.mem_req_wdata = laneData;
            mem.mem_req_wstrb = laneStrb;
         end
         default: ;
      endcase
      mem.mem_req_valid = memReqValid;
   end

   // Request capture, valid bits, refill progress and the registered response
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q     <= '0;
         reqOp_q     <= '0;
         reqAddr_q   <= '0;
         reqWdata_q  <= '0;
         reqRd_q     <= '0;
         reqPc_q     <= '0;
         refillCnt_q <= '0;
         rdPending_q <= 1'b0;
         respValid_q <= 1'b0;
         respData_q  <= '0;
         respHit_q   <= 1'b0;
      end else begin
         respValid_q <= 1'b0;
         if (accept && (isLoad || isStore)) begin
            reqOp_q    <= lsu.req_op;
            reqAddr_q  <= lsu.req_addr;
            reqWdata_q <= lsu.req_wdata;
            reqRd_q    <= lsu.req_rd;
            reqPc_q    <= lsu.req_pc;
         end
         if (accept && isLoad) begin
            if (lookupHit) begin
               respValid_q <= 1'b1;
               respHit_q   <= 1'b1;
               respData_q  <= loadFmt(lsu.req_op, lookupWord, lsu.req_addr[1:0]);
            end else begin
               valid_q[lookupIdx] <= 1'b0;
               refillCnt_q        <= '0;
               rdPending_q        <= 1'b0;
            end
         end
         if (refillIssue) rdPending_q <= 1'b1;
         if (rspFire) begin
            rdPending_q <= 1'b0;
            refillCnt_q <= refillCnt_q + 1'b1;
            if (refillCnt_q == reqWord)
               respData_q <= loadFmt(reqOp_q, mem.mem_rsp_data, reqAddr_q[1:0]);
            if (lastWord) begin
               valid_q[reqIdx] <= 1'b1;
               respValid_q     <= 1'b1;
               respHit_q       <= 1'b0;
            end
         end
         if (writeFire) begin
            respValid_q <= 1'b1;
            respHit_q   <= reqHit;
            respData_q  <= reqWdata_q;
         end
      end
   end

   // Tag and data arrays are deliberately left uninitialised; valid bits guard them
   always_ff @(posedge clk) begin
      if (rspFire) begin
         dataArr_q[reqIdx][refillCnt_q] <= mem.mem_rsp_data;
         if (lastWord) tagArr_q[reqIdx] <= tagOf(reqAddr_q);
      end
      if (writeFire && reqHit) begin
         for (int b = 0; b < 4; b++)
            if (laneStrb[b]) dataArr_q[reqIdx][reqWord][8*b +: 8] <= laneData[8*b +: 8];
      end
   end

   assign lsu.resp_valid = respValid_q;
   assign lsu.resp_op    = reqOp_q;
   assign lsu.resp_rd    = reqRd_q;
   assign lsu.resp_pc    = reqPc_q;
   assign lsu.resp_addr  = reqAddr_q;
   assign lsu.resp_data  = respData_q;
   assign lsu.resp_hit   = respHit_q;

`ifdef DCACHE_STATS_EN
   logic [31:0] hitCnt_q, missCnt_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hitCnt_q  <= '0;
         missCnt_q <= '0;
      end else if (respValid_q) begin
         if (respHit_q) hitCnt_q  <= hitCnt_q + 32'd1;
         else           missCnt_q <= missCnt_q + 32'd1;
      end
   end

   assign hit_cnt  = hitCnt_q;
   assign miss_cnt = missCnt_q;
`endif

endmodule
